// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the 5-stage core.
// It handles load-use stalls, wrong-path squash after an EX redirect, and
// pipe hold while the hardware stack finishes a push or pop.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W    = 3,
  parameter int unsigned IMEM_LAT      = 2,
  parameter int unsigned STACK_TIMEOUT = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_uses_src2,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  ex_mem_read,
  input  logic                  ex_rf_write_en,
  input  logic                  ex_redirect,
  input  logic                  ex_stack_op,
  input  logic                  stack_ready,
  output logic                  pc_write_en,
  output logic                  pr1_write_en,
  output logic                  pr2_write_en,
  output logic                  pr1_flush,
  output logic                  pr2_flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic                  stack_err
);

  localparam int unsigned MAX_WAIT = (IMEM_LAT > STACK_TIMEOUT) ? IMEM_LAT : STACK_TIMEOUT;
  localparam int unsigned WAIT_W   = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIRECT   = 2'd1,
    STACK_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              stack_err_q, stack_err_d;

  logic stack_hold;
  logic load_use;
  logic run_eval;

  assign stack_hold = ex_stack_op & ~stack_ready;
  assign load_use   = id_valid & ex_mem_read & ex_rf_write_en &
                      ((id_src1 == ex_dst) | (id_uses_src2 & (id_src2 == ex_dst)));

  assign stall_count = stall_count_q;
  assign stack_err   = stack_err_q;

  // Next-state and same-cycle control outputs.
  always_comb begin
    pc_write_en  = 1'b1;
    pr1_write_en = 1'b1;
    pr2_write_en = 1'b1;
    pr1_flush    = 1'b0;
    pr2_flush    = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    stack_err_d  = stack_err_q;
    run_eval     = 1'b0;

    case (state_q)
      REDIRECT: begin
        pr1_flush  = 1'b1;
        pr2_flush  = 1'b1;
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_q == WAIT_W'(IMEM_LAT - 1)) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      STACK_WAIT: begin
        if (stack_ready) begin
          // Release cycle: behave exactly like RUN; stack_hold is 0 here.
          run_eval = 1'b1;
        end else if (wait_cnt_q == WAIT_W'(STACK_TIMEOUT - 1)) begin
          // Abort: keep the front end frozen and kill the stuck EX op.
          pc_write_en  = 1'b0;
          pr1_write_en = 1'b0;
          pr2_flush    = 1'b1;
          stack_err_d  = 1'b1;
          state_d      = RUN;
          wait_cnt_d   = '0;
        end else begin
          pc_write_en  = 1'b0;
          pr1_write_en = 1'b0;
          pr2_write_en = 1'b0;
          wait_cnt_d   = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: run_eval = 1'b1;
    endcase

    if (run_eval) begin
      state_d = RUN;
      if (stack_hold) begin
        pc_write_en  = 1'b0;
        pr1_write_en = 1'b0;
        pr2_write_en = 1'b0;
        state_d      = STACK_WAIT;
        wait_cnt_d   = WAIT_W'(1);
      end else if (ex_redirect) begin
        pr1_flush = 1'b1;
        pr2_flush = 1'b1;
        if (IMEM_LAT > 1) begin
          state_d    = REDIRECT;
          wait_cnt_d = WAIT_W'(1);
        end
      end else if (load_use) begin
        pc_write_en  = 1'b0;
        pr1_write_en = 1'b0;
        pr2_flush    = 1'b1;
      end
    end

    // Reset forces a fully frozen, flushed pipe in the same cycle.
    if (!rst) begin
      pc_write_en  = 1'b0;
      pr1_write_en = 1'b0;
      pr2_write_en = 1'b0;
      pr1_flush    = 1'b1;
      pr2_flush    = 1'b1;
    end

    stall_count_d = stall_count_q;
    if (!pc_write_en && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // State, wait counter, stall counter and sticky error with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      stack_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      stack_err_q   <= stack_err_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, checked every cycle against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned IMEM_LAT = 2;
  localparam int unsigned STO      = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_src1, id_src2, ex_dst;
  logic       id_uses_src2, ex_mem_read, ex_rf_write_en;
  logic       ex_redirect, ex_stack_op, stack_ready;

  logic        pc_write_en, pr1_write_en, pr2_write_en, pr1_flush, pr2_flush, stack_err;
  logic [15:0] stall_count;
  logic        pc_w4, pr1_w4, pr2_w4, f1_w4, f2_w4, err_w4;
  logic [3:0]  stall_count4;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(3), .IMEM_LAT(IMEM_LAT), .STACK_TIMEOUT(STO), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src2(id_uses_src2), .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
    .ex_rf_write_en(ex_rf_write_en), .ex_redirect(ex_redirect), .ex_stack_op(ex_stack_op),
    .stack_ready(stack_ready), .pc_write_en(pc_write_en), .pr1_write_en(pr1_write_en),
    .pr2_write_en(pr2_write_en), .pr1_flush(pr1_flush), .pr2_flush(pr2_flush),
    .stall_count(stall_count), .stack_err(stack_err)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(3), .IMEM_LAT(IMEM_LAT), .STACK_TIMEOUT(STO), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src2(id_uses_src2), .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
    .ex_rf_write_en(ex_rf_write_en), .ex_redirect(ex_redirect), .ex_stack_op(ex_stack_op),
    .stack_ready(stack_ready), .pc_write_en(pc_w4), .pr1_write_en(pr1_w4),
    .pr2_write_en(pr2_w4), .pr1_flush(f1_w4), .pr2_flush(f2_w4),
    .stall_count(stall_count4), .stack_err(err_w4)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining redirect-kill cycles, cycles spent holding for
  // the stack, total stalled cycles, sticky error.
  int m_redir  = 0;
  int m_swait  = 0;
  int m_stalls = 0;
  bit m_err    = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic idle_inputs();
    rst = 1'b1; id_valid = 1'b0; id_src1 = 3'd0; id_src2 = 3'd0; id_uses_src2 = 1'b0;
    ex_dst = 3'd0; ex_mem_read = 1'b0; ex_rf_write_en = 1'b0; ex_redirect = 1'b0;
    ex_stack_op = 1'b0; stack_ready = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rf_write_en = 1'b1; ex_dst = 3'd3; id_valid = 1'b1;
    id_src1 = 3'd3; id_src2 = 3'd0; id_uses_src2 = 1'b1;
  endtask

  // One clock cycle: sample at negedge+1, compare with the model, advance the model.
  task automatic step();
    bit       lu;
    bit       e_pc, e_p1, e_p2, e_f1, e_f2;
    bit       err_next;
    @(negedge clk); #1;
    check_val("stall_count", 32'(stall_count), 32'(sat(m_stalls, 65535)));
    check_val("stall_count_w4", 32'(stall_count4), 32'(sat(m_stalls, 15)));
    check_val("stack_err", 32'(stack_err), 32'(m_err));
    check_val("stack_err_w4", 32'(err_w4), 32'(m_err));

    lu = id_valid && ex_mem_read && ex_rf_write_en &&
         ((id_src1 == ex_dst) || (id_uses_src2 && (id_src2 == ex_dst)));
    {e_pc, e_p1, e_p2, e_f1, e_f2} = 5'b11100;
    err_next = m_err;

    if (!rst) begin
      {e_pc, e_p1, e_p2, e_f1, e_f2} = 5'b00011;
    end else if (m_redir > 0) begin
      e_f1 = 1'b1; e_f2 = 1'b1;
      m_redir--;
    end else if (m_swait > 0 && !stack_ready) begin
      if (m_swait + 1 == int'(STO)) begin
        e_pc = 1'b0; e_p1 = 1'b0; e_f2 = 1'b1;
        err_next = 1'b1;
        m_swait = 0;
      end else begin
        {e_pc, e_p1, e_p2} = 3'b000;
        m_swait++;
      end
    end else if (m_swait == 0 && ex_stack_op && !stack_ready) begin
      {e_pc, e_p1, e_p2} = 3'b000;
      m_swait = 1;
    end else begin
      m_swait = 0;
      if (ex_redirect) begin
        e_f1 = 1'b1; e_f2 = 1'b1;
        m_redir = int'(IMEM_LAT) - 1;
      end else if (lu) begin
        e_pc = 1'b0; e_p1 = 1'b0; e_f2 = 1'b1;
      end
    end

    check_val("ctrl{pc,pr1,pr2,f1,f2}",
              32'({pc_write_en, pr1_write_en, pr2_write_en, pr1_flush, pr2_flush}),
              32'({e_pc, e_p1, e_p2, e_f1, e_f2}));
    check_val("ctrl_w4", 32'({pc_w4, pr1_w4, pr2_w4, f1_w4, f2_w4}),
              32'({e_pc, e_p1, e_p2, e_f1, e_f2}));

    if (!rst) begin
      m_redir = 0; m_swait = 0; m_stalls = 0; m_err = 1'b0;
    end else begin
      if (!e_pc) m_stalls++;
      m_err = err_next;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(); step();
    rst = 1'b1; step();

    // Load-use on src1, then src2 match that must be ignored when unused.
    set_load_use(); step();
    idle_inputs(); step();
    set_load_use(); id_src1 = 3'd1; id_src2 = 3'd3; id_uses_src2 = 1'b0; step();
    id_uses_src2 = 1'b1; step();
    idle_inputs(); step();

    // Redirect, with a load-use pattern during the second kill cycle.
    ex_redirect = 1'b1; step();
    idle_inputs(); set_load_use(); step();
    idle_inputs(); step();

    // Stack wait released after 3 cycles.
    ex_stack_op = 1'b1; repeat (3) step();
    stack_ready = 1'b1; step();
    idle_inputs(); step();

    // Stack timeout.
    ex_stack_op = 1'b1; repeat (STO) step();
    idle_inputs(); repeat (2) step();

    // Stack return: hold first, redirect in the release cycle.
    ex_stack_op = 1'b1; ex_redirect = 1'b1; repeat (2) step();
    stack_ready = 1'b1; step();
    idle_inputs(); repeat (2) step();

    // Reset in the middle of a stack wait.
    ex_stack_op = 1'b1; repeat (2) step();
    rst = 1'b0; step();
    idle_inputs(); step();

    // Long load-use run saturates the narrow counter.
    set_load_use(); repeat (20) step();
    idle_inputs(); step();

    // Random traffic, alternating between short and long stack latencies.
    for (int i = 0; i < 3000; i++) begin
      bit slow;
      slow           = ((i / 250) % 2) == 1;
      rst            = ($urandom_range(0, 199) != 0);
      id_valid       = ($urandom_range(0, 3) != 0);
      id_src1        = 3'($urandom_range(0, 7));
      id_src2        = 3'($urandom_range(0, 7));
      id_uses_src2   = 1'($urandom_range(0, 1));
      ex_dst         = ($urandom_range(0, 2) == 0) ? id_src1 : 3'($urandom_range(0, 7));
      ex_mem_read    = 1'($urandom_range(0, 1));
      ex_rf_write_en = ($urandom_range(0, 3) != 0);
      ex_redirect    = ($urandom_range(0, 7) == 0);
      ex_stack_op    = ($urandom_range(0, 5) == 0);
      stack_ready    = slow ? ($urandom_range(0, 11) == 0) : 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline control unit for the 5-stage core. It drives the PC enable and the enable/flush of the IF/ID and ID/EX pipeline registers. It detects load-use hazards, squashes wrong-path instructions after a taken branch, jump or return resolved in EX, and holds the pipe while the hardware stack completes a push or pop. It sits beside the decoder, with inputs taken from the ID-stage instruction fields and the ID/EX register outputs.

## Interface
- REG_ADDR_W, 3: register-file address width
- IMEM_LAT, 2: cycles of IF/ID flush after a redirect (≥1)
- STACK_TIMEOUT, 8: max STACK_WAIT cycles before forced abort (≥2)
- CNT_W, 16: stall counter width
- clk  in  1  clock, all state on posedge
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  ID stage holds a real instruction
- id_src1, id_src2  in  REG_ADDR_W  ID source registers
- id_uses_src2  in  1  instruction reads id_src2
- ex_dst  in  REG_ADDR_W  EX destination register
- ex_mem_read, ex_rf_write_en  in  1  EX control bits from ID/EX
- ex_redirect  in  1  EX resolved a taken branch, jump or return
- ex_stack_op  in  1  EX instruction pushes or pops
- stack_ready  in  1  stack completes its op this cycle
- pc_write_en  out  1  PC update enable
- pr1_write_en, pr2_write_en  out  1  IF/ID and ID/EX load enables
- pr1_flush, pr2_flush  out  1  load a bubble (all-zero) into IF/ID or ID/EX
- stall_count  out  CNT_W  saturating count of cycles with pc_write_en=0
- stack_err  out  1  sticky, set on stack timeout

## Operation
- Outputs are combinational from the state, the inputs and rst; the state registers are FSM, wait_cnt, stall_count and stack_err.
- States: RUN, REDIRECT, STACK_WAIT.
- Default outputs: all enables 1, flushes 0.
- stack_hold = ex_stack_op & !stack_ready.
- load_use = id_valid & ex_mem_read & ex_rf_write_en & (id_src1==ex_dst | (id_uses_src2 & id_src2==ex_dst)).

RUN evaluates in priority order:
1. stack_hold: all enables 0 and no flush; next state STACK_WAIT with wait_cnt←1.
2. ex_redirect: pr1_flush=1 and pr2_flush=1, PC loads the target. If IMEM_LAT>1, next state REDIRECT with wait_cnt←1; otherwise stay in RUN.
3. load_use: pc_write_en=0, pr1_write_en=0, pr2_flush=1. Stay in RUN; the bubble clears the hazard next cycle.

REDIRECT:
- pr1_flush=1, pr2_flush=1, pc_write_en=1. ex_* and load_use are ignored.
- wait_cnt increments each cycle. When wait_cnt==IMEM_LAT-1, return to RUN.

STACK_WAIT:
- If stack_ready=1, the outputs and next state are exactly RUN's with stack_hold treated as 0 (release cycle).
- Else, if wait_cnt==STACK_TIMEOUT-1: abort. pc_write_en=0, pr1_write_en=0, pr2_write_en=1, pr2_flush=1 (kill the EX op); stack_err←1; next state RUN.
- Else all enables 0; wait_cnt increments.

Counters and reset:
- stall_count increments on every non-reset cycle with pc_write_en=0 and saturates at 2^CNT_W-1.
- While rst=0: outputs are pc_write_en=0, pr1_write_en=0, pr2_write_en=0, pr1_flush=1, pr2_flush=1. At the edge, state←RUN, wait_cnt←0, stall_count←0, stack_err←0.
- Reset mid-REDIRECT or mid-STACK_WAIT aborts silently; stack_err is not set.

## Timing
- Zero-latency control: the response appears in the same cycle as the triggering inputs.
- Load-use stall: exactly 1 cycle.
- Redirect: wrong-path kill lasts IMEM_LAT cycles, including the redirect cycle.
- Stack wait: holds N cycles while stack_ready=0, then releases in the cycle stack_ready=1. Abort occurs at STACK_TIMEOUT cycles total.
- A stack return (ex_stack_op=1, ex_redirect=1, stack_ready=0): waits first, then redirects in the release cycle.

## Test plan
- Load-use: ex_mem_read=1, ex_rf_write_en=1, ex_dst=3, id_valid=1, id_src1=3 → 1 cycle of pc_write_en=0, pr1_write_en=0, pr2_flush=1; stall_count=1. Repeat with id_uses_src2=0 and id_src2=3 → no stall.
- Redirect with IMEM_LAT=2: pulse ex_redirect → pr1_flush=1 and pr2_flush=1 for exactly 2 cycles, pc_write_en=1 throughout, back to RUN. A load_use pattern during cycle 2 is ignored.
- Stack wait: ex_stack_op=1, stack_ready=0 for 3 cycles, then 1 → enables 0 for 3 cycles, all 1 on the 4th; stall_count=3; stack_err=0.
- Stack timeout with STACK_TIMEOUT=8: stack_ready held at 0 → 7 full-stall cycles, then 1 abort cycle (pr2_flush=1, pr2_write_en=1); stack_err=1 from the next cycle and stays 1 until reset.
- Priority: ex_stack_op=1, ex_redirect=1, stack_ready=0 for 2 cycles, then 1 → 2 stall cycles, then a release cycle with pr1_flush=1 and pr2_flush=1, then REDIRECT.
- Reset: assert rst=0 mid-STACK_WAIT → same-cycle outputs are enables 0 and flushes 1; after release, state is RUN, stall_count=0, stack_err=0. With CNT_W=4, 20 load-use stalls → stall_count=15.
